// File: rtl/pc_next_ctrl.sv
// Next-PC selection for the Pc/nextPc loop: reset vector, sequential step,
// jump/branch redirect, hold, and replay of redirects captured during a hold.
// Optional feature macro: PC_NEXT_CTRL_MISALIGN_TRAP_EN (misaligned targets
// trap to TRAP_VECTOR and pulse misalign_err; otherwise low bits are masked).
module pc_next_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
`endif
   parameter int unsigned PC_STEP      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Pc,
   input  logic        jump_req,
   input  logic [31:0] jump_target,
   input  logic        branch_req,
   input  logic [31:0] branch_target,
   input  logic        stall,
   input  logic        fetch_ready,
   output logic [31:0] nextPc,
   output logic        fetch_valid,
   output logic        flush,
   output logic        redirect_pending
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
   ,output logic       misalign_err
`endif
);

   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {BOOT, RUN, HOLD, REPLAY} state_t;

   state_t          state_q, state_d;
   logic            pend_q, pend_d;
   logic [AW-1:0]   pend_tgt_q, pend_tgt_d;

   logic            hold;
   logic            redir;
   logic [AW-1:0]   redir_tgt;
   logic            issue;
   logic [AW-1:0]   issue_tgt;
   logic [AW-1:0]   next_pc_c;
   logic            fetch_valid_c;
   logic            flush_c;
   logic            misalign_c;

   // State and pending-redirect registers; pc_register holds the PC itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   // Next-state, pending capture and nextPc selection.
   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pend_tgt_d    = pend_tgt_q;
      issue         = 1'b0;
      issue_tgt     = '0;
      next_pc_c     = Pc;
      fetch_valid_c = 1'b0;
      flush_c       = 1'b0;
      misalign_c    = 1'b0;

      hold      = stall | ~fetch_ready;
      redir     = jump_req | branch_req;
      redir_tgt = jump_req ? jump_target : branch_target;

      case (state_q)
         BOOT: begin
            // Vector is issued regardless of hold so pc_register always loads it.
            next_pc_c     = RESET_VECTOR;
            fetch_valid_c = 1'b1;
            pend_d        = 1'b0;
            state_d       = RUN;
         end
         RUN, REPLAY: begin
            if (hold) begin
               state_d = HOLD;
               if (redir) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
            end else begin
               state_d       = RUN;
               fetch_valid_c = 1'b1;
               if (redir) begin
                  issue     = 1'b1;
                  issue_tgt = redir_tgt;
               end else begin
                  next_pc_c = Pc + AW'(PC_STEP);
               end
            end
         end
         HOLD: begin
            if (hold) begin
               // Newest redirect replaces any older pending one.
               if (redir) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
            end else begin
               fetch_valid_c = 1'b1;
               pend_d        = 1'b0;
               state_d       = pend_q ? REPLAY : RUN;
               if (redir) begin
                  issue     = 1'b1;
                  issue_tgt = redir_tgt;
               end else if (pend_q) begin
                  issue     = 1'b1;
                  issue_tgt = pend_tgt_q;
               end else begin
                  next_pc_c = Pc + AW'(PC_STEP);
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      // A redirect going out squashes the fetch at the old PC.
      if (issue) begin
         flush_c = 1'b1;
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
         if (issue_tgt[1:0] != 2'b00) begin
            next_pc_c  = TRAP_VECTOR;
            misalign_c = 1'b1;
         end else begin
            next_pc_c = issue_tgt;
         end
`else
         next_pc_c = issue_tgt & ~AW'(3);
`endif
      end
   end

   // Reset forces the vector out and suppresses fetch/flush immediately.
   always_comb begin
      nextPc           = rst_n ? next_pc_c : RESET_VECTOR;
      fetch_valid      = rst_n & fetch_valid_c;
      flush            = rst_n & flush_c;
      redirect_pending = pend_q;
   end

`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
   assign misalign_err = rst_n & misalign_c;
`else
   logic unused_misalign;
   assign unused_misalign = misalign_c;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed scenarios plus random traffic, checked by
// a scoreboard against a rule-level model of the next-PC behaviour.
module tb_pc_next_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc;
   logic        jump_req = 1'b0, branch_req = 1'b0, stall = 1'b0, fetch_ready = 1'b1;
   logic [31:0] jump_target = '0, branch_target = '0;
   logic [31:0] nextPc;
   logic        fetch_valid, flush, redirect_pending;
   logic        misalign_err;
   logic        ld = 1'b0;
   logic [31:0] ld_val = '0;

   typedef struct {
      logic [31:0] npc;
      logic        fv;
      logic        fl;
      logic        rp;
      logic        me;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pend[$];
   logic [31:0] model_pc;
   bit          first;
   int          n_tests = 0;
   int          n_fail  = 0;

   pc_next_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Pc(pc),
      .jump_req(jump_req), .jump_target(jump_target),
      .branch_req(branch_req), .branch_target(branch_target),
      .stall(stall), .fetch_ready(fetch_ready),
      .nextPc(nextPc), .fetch_valid(fetch_valid), .flush(flush),
      .redirect_pending(redirect_pending)
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
      , .misalign_err(misalign_err)
`endif
   );
`ifndef PC_NEXT_CTRL_MISALIGN_TRAP_EN
   assign misalign_err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Stand-in for pc_register, with a bench-side load to place Pc directly.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  pc <= RV;
      else if (ld) pc <= ld_val;
      else         pc <= nextPc;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: DUT presents a decision every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("nextPc", nextPc, e.npc);
         chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
         chk("flush", 32'(flush), 32'(e.fl));
         chk("redirect_pending", 32'(redirect_pending), 32'(e.rp));
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
         chk("misalign_err", 32'(misalign_err), 32'(e.me));
`endif
      end
   end

   // One cycle of stimulus; the model derives the expected decision from the rules.
   task automatic drive(input bit j, input logic [31:0] jt, input bit b,
                        input logic [31:0] bt, input bit st, input bit fr);
      exp_t        e;
      logic [31:0] tgt;
      bit          red, hold;
      @(posedge clk);
      #1;
      ld = 1'b0;
      rst_n = 1'b1;
      jump_req = j; jump_target = jt; branch_req = b; branch_target = bt;
      stall = st; fetch_ready = fr;
      hold = st || !fr;
      red  = j || b;
      tgt  = j ? jt : bt;
      e.rp = (pend.size() != 0);
      e.fl = 1'b0; e.me = 1'b0;
      if (first) begin
         e.npc = RV; e.fv = 1'b1; first = 1'b0;
      end else if (hold) begin
         e.npc = model_pc; e.fv = 1'b0;
         if (red) pend.push_back(tgt);
      end else begin
         e.fv = 1'b1;
         if (red || pend.size() != 0) begin
            if (!red) tgt = pend[$];
            e.fl = 1'b1;
`ifdef PC_NEXT_CTRL_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin e.npc = TV; e.me = 1'b1; end
            else e.npc = tgt;
`else
            e.npc = (tgt / 4) * 4;
`endif
         end else begin
            e.npc = model_pc + 32'd4;
         end
         pend.delete();
      end
      model_pc = e.npc;
      sb.push_back(e);
   endtask

   task automatic idle();
      drive(0, '0, 0, '0, 0, 1);
   endtask

   task automatic load_pc(input logic [31:0] v);
      idle();
      ld = 1'b1; ld_val = v; model_pc = v;
   endtask

   // Asynchronous reset mid-cycle; outputs must collapse at once.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst nextPc", nextPc, RV);
      chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst flush", 32'(flush), 32'd0);
      chk("rst redirect_pending", 32'(redirect_pending), 32'd0);
      chk("rst Pc", pc, RV);
      repeat (2) @(posedge clk);
      pend.delete();
      first = 1'b1;
      model_pc = RV;
   endtask

   initial begin
      first = 1'b1;
      model_pc = RV;
      #3;
      chk("reset nextPc", nextPc, RV);
      chk("reset fetch_valid", 32'(fetch_valid), 32'd0);
      chk("reset redirect_pending", 32'(redirect_pending), 32'd0);
      repeat (2) @(posedge clk);

      // Boot then sequential fetch 0x0, 0x4, 0x8, 0xC.
      repeat (5) idle();
      // Boot with hold asserted still issues the vector.
      pulse_reset();
      drive(0, '0, 0, '0, 1, 1);
      idle();
      // Jump wins over simultaneous branch, then sequential from target.
      load_pc(32'h10);
      drive(1, 32'h200, 1, 32'h300, 0, 1);
      idle();
      // Branch captured during stall, replayed on release.
      load_pc(32'h20);
      drive(0, '0, 1, 32'h400, 1, 1);
      drive(0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 1);
      idle();
      idle();
      // Newest pending wins; fresh redirect at release beats pending.
      drive(1, 32'h600, 0, '0, 1, 1);
      drive(0, '0, 1, 32'h700, 0, 0);
      drive(0, '0, 1, 32'h800, 0, 1);
      idle();
      // Wrap at top of address space.
      load_pc(32'hFFFF_FFFC);
      idle();
      idle();
      // Pending 0x500 discarded by reset mid-stall.
      drive(1, 32'h500, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 1);
      pulse_reset();
      repeat (3) idle();
      // Misaligned target.
      drive(1, 32'h102, 0, '0, 0, 1);
      idle();

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         bit          j, b, st, fr;
         logic [31:0] jt, bt;
         j  = ($urandom_range(0, 99) < 15);
         b  = ($urandom_range(0, 99) < 20);
         st = ($urandom_range(0, 99) < 30);
         fr = ($urandom_range(0, 99) < 85);
         jt = $urandom();
         bt = $urandom();
         drive(j, jt, b, bt, st, fr);
         if (i % 500 == 250) pulse_reset();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Produces the nextPc word consumed by pc_register every clk rising edge; the producer side of the Pc/nextPc loop.
- Selects between sequential fetch (Pc+4), jump, branch redirect, pipeline stall and the reset vector.
- Holds pending redirects that arrive during a stall and replays them when the stall clears.
- Sits between the decode/execute redirect sources and pc_register in the single-cycle/pipelined datapath.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC issued after reset.
- TRAP_VECTOR, 32'h0000_0080, redirect target for misaligned targets (optional feature only).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock shared with pc_register.
- rst_n  input  1  asynchronous active-low reset.
- Pc  input  32  current PC from pc_register.
- jump_req  input  1  unconditional jump request, valid this cycle.
- jump_target  input  32  jump destination.
- branch_req  input  1  taken-branch request, valid this cycle.
- branch_target  input  32  branch destination.
- stall  input  1  pipeline hold request.
- fetch_ready  input  1  instruction memory can accept a new address.
- nextPc  output  32  value pc_register latches on the next edge.
- fetch_valid  output  1  nextPc is a new fetch address (not a hold).
- flush  output  1  one-cycle pulse: squash the instruction fetched at the old PC.
- redirect_pending  output  1  a redirect is latched and waiting.
- misalign_err  output  1  present only with MISALIGN_TRAP_EN.

Behaviour:
- Effective hold: hold = stall | ~fetch_ready.
- States, registered: BOOT, RUN, HOLD, REPLAY.
- Reset (rst_n low, asynchronous): state=BOOT, pending register cleared, redirect_pending=0, flush=0, fetch_valid=0, nextPc=RESET_VECTOR.
- BOOT: nextPc=RESET_VECTOR, fetch_valid=1. Go to RUN on the first edge after rst_n rises, even if hold is asserted, so pc_register always loads the vector.
- Redirect priority: jump_req over branch_req. Both asserted -> jump_target wins and the branch is dropped.
- RUN, no hold:
  - Redirect present -> nextPc=target, flush=1, fetch_valid=1.
  - No redirect -> nextPc=Pc+PC_STEP, fetch_valid=1, flush=0.
- RUN, hold:
  - nextPc=Pc, fetch_valid=0. Go to HOLD.
  - A redirect present in the same cycle is captured into the pending register, redirect_pending=1.
- HOLD, hold still high:
  - nextPc=Pc, fetch_valid=0.
  - A new redirect overwrites the pending one, with jump still winning within a cycle. The newest redirect wins across cycles.
- HOLD, hold released:
  - redirect_pending=1 -> go to REPLAY in the same cycle: nextPc=pending target, flush=1, fetch_valid=1. Clear pending on the edge, then return to RUN.
  - A fresh redirect in the release cycle overrides the pending one.
  - No pending -> nextPc=Pc+PC_STEP, go to RUN.
- flush: asserted only in the cycle nextPc carries a redirect. Never asserted while hold=1.
- Arithmetic:
  - Pc+PC_STEP is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
  - Targets have bits[1:0] forced to 0 when the optional feature is absent.
- Reset mid-stall or mid-pending: all state is discarded; BOOT is re-entered immediately and asynchronously.
- nextPc is combinational from Pc, the inputs and registered state. pc_register provides the only PC storage, so redirect latency is zero cycles: a redirect in cycle N makes Pc equal the target after edge N.

Optional Feature:
- Macro: PC_NEXT_CTRL_MISALIGN_TRAP_EN.
- Defined:
  - A selected target with bits[1:0]!=0 replaces nextPc with TRAP_VECTOR, asserts flush=1, and pulses misalign_err=1 for that cycle.
  - A pending replay is checked the same way.
- Undefined:
  - The misalign_err port is absent.
  - Low target bits are silently masked to 0.

Test Plan:
- Reset release, no hold, 4 edges -> Pc sequence 0x0, 0x4, 0x8, 0xC. fetch_valid=1 throughout, flush=0.
- Pc=0x10, jump_req=1 to 0x200 and branch_req=1 to 0x300 together -> nextPc=0x200, flush=1 for one cycle, next Pc=0x204.
- Pc=0x20, stall=1 for 3 cycles with branch_req to 0x400 in stall cycle 1 -> Pc holds 0x20, redirect_pending=1. Release -> nextPc=0x400 with flush=1; after the edge redirect_pending=0.
- Pc=0xFFFFFFFC, no hold -> nextPc=0x00000000, no flag, flush=0.
- Pending redirect 0x500 latched during stall, rst_n pulsed low mid-stall -> nextPc=RESET_VECTOR immediately, redirect_pending=0; 0x500 is never issued.
- MISALIGN_TRAP_EN defined: jump_target=0x102 -> nextPc=0x80, misalign_err=1 for one cycle, flush=1. Undefined: nextPc=0x100.
